// File: rtl/aes_pkg.sv
// Shared AES constants: block width, legal round counts and scheduler state encoding.
package aes_pkg;

  localparam int AES_BLK_W  = 128;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN_A = 3'd1;
  localparam logic [2:0] ST_RUN_B = 3'd2;
  localparam logic [2:0] ST_FIN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_round_sched.sv
// Iterative AES round scheduler: one block in flight, ciphertext valid 2*NR+2 cycles after accept.
// The result is held in DONE until out_ready; a new block can be accepted in that same cycle.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [3:0]           key_idx,
  input  logic [AES_BLK_W-1:0] key_data,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic                 rnd_final,
  input  logic [AES_BLK_W-1:0] rnd_result,
  output logic                 busy
);

  logic [2:0] state;
  logic [3:0] rnd;
  aes_blk_t   st_reg;
  logic       in_run;
  logic       last_rnd;
  logic       accept;

  assign in_run    = (state == ST_RUN_A) || (state == ST_RUN_B);
  assign last_rnd  = (rnd == 4'(NR));
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign rnd_final = in_run && last_rnd;
  assign key_idx   = in_run ? rnd : 4'd0;

  // Later rounds issue straight from the round unit; st_reg keeps that value for the key cycle.
  assign rnd_state = ((state == ST_RUN_A) && (rnd != 4'd1)) ? rnd_result : st_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rnd      <= 4'd0;
      st_reg   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            st_reg <= in_data ^ key_data;
            rnd    <= 4'd1;
            state  <= ST_RUN_A;
          end
        end
        ST_RUN_A: begin
          if (rnd != 4'd1) begin
            st_reg <= rnd_result;
          end
          state <= ST_RUN_B;
        end
        ST_RUN_B: begin
          if (last_rnd) begin
            state <= ST_FIN;
          end else begin
            rnd   <= rnd + 4'd1;
            state <= ST_RUN_A;
          end
        end
        ST_FIN: begin
          out_data <= rnd_result;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              st_reg <= in_data ^ key_data;
              rnd    <= 4'd1;
              state  <= ST_RUN_A;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
